// File: rtl/iob_counter_mod_pkg.sv
// Shared constants for the modulo up/down counter: mode and direction encodings
// plus the internal arithmetic width helper.
package iob_counter_mod_pkg;

   localparam logic WRAP = 1'b0;
   localparam logic SAT  = 1'b1;

   localparam logic UP   = 1'b0;
   localparam logic DOWN = 1'b1;

   // One spare bit above DATA_W+STEP_W keeps cur+step and the wrap terms exact.
   function automatic int calc_int_w(input int data_w, input int step_w);
      return data_w + step_w + 1;
   endfunction

endpackage

// File: rtl/iob_counter_mod_next.sv
// Combinational next-value calculator: produces the counted value and flags
// whether the requested step left the [MIN_VAL, MAX_VAL] range.
module iob_counter_mod_next
   import iob_counter_mod_pkg::*;
#(
   parameter int   DATA_W   = 8,
   parameter int   STEP_W   = 4,
   parameter int   MIN_VAL  = 0,
   parameter int   MAX_VAL  = 2**DATA_W - 1,
   parameter logic SAT_MODE = WRAP
) (
   input  logic [DATA_W-1:0] cur_i,
   input  logic              dir_i,
   input  logic [STEP_W-1:0] step_i,
   output logic [DATA_W-1:0] next_o,
   output logic              oor_o
);

   localparam int INT_W = calc_int_w(DATA_W, STEP_W);

   localparam logic [INT_W-1:0] MIN_W = INT_W'(MIN_VAL);
   localparam logic [INT_W-1:0] MAX_W = INT_W'(MAX_VAL);

   logic [INT_W-1:0] cur_w;
   logic [INT_W-1:0] step_w;
   logic [INT_W-1:0] sum_w;
   logic [INT_W-1:0] above_min_w;
   logic [INT_W-1:0] nxt_w;

   assign cur_w       = INT_W'(cur_i);
   assign step_w      = INT_W'(step_i);
   assign sum_w       = cur_w + step_w;
   assign above_min_w = cur_w - MIN_W;

   always_comb begin
      nxt_w = cur_w;
      oor_o = 1'b0;
      if (dir_i == UP) begin
         oor_o = (sum_w > MAX_W);
         if (!oor_o)
            nxt_w = sum_w;
         else if (SAT_MODE == SAT)
            nxt_w = MAX_W;
         else
            nxt_w = MIN_W + (sum_w - MAX_W - INT_W'(1));
      end else begin
         oor_o = (above_min_w < step_w);
         if (!oor_o)
            nxt_w = cur_w - step_w;
         else if (SAT_MODE == SAT)
            nxt_w = MIN_W;
         else
            nxt_w = MAX_W - (step_w - above_min_w - INT_W'(1));
      end
   end

   assign next_o = nxt_w[DATA_W-1:0];

endmodule

// File: rtl/iob_counter_mod.sv
// Modulo up/down counter with step, parallel load, bounded range, wrap or
// saturate behaviour, terminal-count pulse and sticky overflow flag.
module iob_counter_mod
   import iob_counter_mod_pkg::*;
#(
   parameter int   DATA_W   = 8,
   parameter int   STEP_W   = 4,
   parameter int   RST_VAL  = 0,
   parameter int   MIN_VAL  = 0,
   parameter int   MAX_VAL  = 2**DATA_W - 1,
   parameter logic SAT_MODE = WRAP
) (
   input  logic              clk_i,
   input  logic              cke_i,
   input  logic              rst_i,
   input  logic              counter_rst_i,
   input  logic              counter_en_i,
   input  logic              dir_i,
   input  logic [STEP_W-1:0] step_i,
   input  logic              load_i,
   input  logic [DATA_W-1:0] load_val_i,
   input  logic              ovf_clr_i,
   output logic [DATA_W-1:0] data_o,
   output logic              tc_o,
   output logic              ovf_o
);

   localparam logic [DATA_W-1:0] RST_D = DATA_W'(RST_VAL);
   localparam logic [DATA_W-1:0] MIN_D = DATA_W'(MIN_VAL);
   localparam logic [DATA_W-1:0] MAX_D = DATA_W'(MAX_VAL);

   logic [DATA_W-1:0] data_q, data_d;
   logic              tc_q, tc_d;
   logic              ovf_q, ovf_d;
   logic [DATA_W-1:0] next_val;
   logic              next_oor;
   logic [DATA_W-1:0] load_clamped;

   iob_counter_mod_next #(
      .DATA_W   (DATA_W),
      .STEP_W   (STEP_W),
      .MIN_VAL  (MIN_VAL),
      .MAX_VAL  (MAX_VAL),
      .SAT_MODE (SAT_MODE)
   ) u_next (
      .cur_i  (data_q),
      .dir_i  (dir_i),
      .step_i (step_i),
      .next_o (next_val),
      .oor_o  (next_oor)
   );

   always_comb begin
      load_clamped = load_val_i;
      if (load_val_i < MIN_D)
         load_clamped = MIN_D;
      else if (load_val_i > MAX_D)
         load_clamped = MAX_D;
   end

   // Clear and set of ovf are ordered so that a same-cycle overflow wins.
   always_comb begin
      data_d = data_q;
      tc_d   = tc_q;
      ovf_d  = ovf_q;
      if (cke_i) begin
         tc_d  = 1'b0;
         ovf_d = ovf_q & ~ovf_clr_i;
         if (counter_rst_i) begin
            data_d = RST_D;
            ovf_d  = 1'b0;
         end else if (load_i) begin
            data_d = load_clamped;
         end else if (counter_en_i) begin
            data_d = next_val;
            tc_d   = next_oor;
            if (next_oor)
               ovf_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         data_q <= RST_D;
         tc_q   <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         tc_q   <= tc_d;
         ovf_q  <= ovf_d;
      end
   end

   assign data_o = data_q;
   assign tc_o   = tc_q;
   assign ovf_o  = ovf_q;

   step_in_range_a : assert property (@(posedge clk_i) disable iff (rst_i)
      (SAT_MODE == WRAP && cke_i && counter_en_i && !counter_rst_i && !load_i)
      |-> (int'(step_i) <= MAX_VAL - MIN_VAL + 1));

endmodule

// File: tb/tb_iob_counter_mod.sv
// Directed bench for the modulo counter: a wrap-mode instance driven from a
// vector table and a saturate-mode instance checked with hand-written sequences.
module tb_iob_counter_mod;

   logic       clk_i = 1'b0;
   logic       cke_i = 1'b0;
   logic       rst_i = 1'b0;
   logic       counter_rst_i = 1'b0;
   logic       counter_en_i = 1'b0;
   logic       dir_i = 1'b0;
   logic [3:0] step_i = '0;
   logic       load_i = 1'b0;
   logic [7:0] load_val_i = '0;
   logic       ovf_clr_i = 1'b0;

   logic [7:0] w_data, s_data;
   logic       w_tc, s_tc, w_ovf, s_ovf;

   int total = 0;
   int bad = 0;

   always #5 clk_i = ~clk_i;

   iob_counter_mod #(
      .DATA_W(8), .STEP_W(4), .RST_VAL(0), .MIN_VAL(0), .MAX_VAL(9), .SAT_MODE(1'b0)
   ) u_wrap (
      .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i), .counter_rst_i(counter_rst_i),
      .counter_en_i(counter_en_i), .dir_i(dir_i), .step_i(step_i), .load_i(load_i),
      .load_val_i(load_val_i), .ovf_clr_i(ovf_clr_i),
      .data_o(w_data), .tc_o(w_tc), .ovf_o(w_ovf)
   );

   iob_counter_mod #(
      .DATA_W(8), .STEP_W(4), .RST_VAL(0), .MIN_VAL(0), .MAX_VAL(9), .SAT_MODE(1'b1)
   ) u_sat (
      .clk_i(clk_i), .cke_i(cke_i), .rst_i(rst_i), .counter_rst_i(counter_rst_i),
      .counter_en_i(counter_en_i), .dir_i(dir_i), .step_i(step_i), .load_i(load_i),
      .load_val_i(load_val_i), .ovf_clr_i(ovf_clr_i),
      .data_o(s_data), .tc_o(s_tc), .ovf_o(s_ovf)
   );

   typedef struct {
      logic       cke;
      logic       crst;
      logic       en;
      logic       dir;
      logic [3:0] step;
      logic       load;
      logic [7:0] lv;
      logic       clr;
      logic [7:0] ed;
      logic       et;
      logic       eo;
   } vec_t;

   vec_t vecs[20];

   function automatic vec_t mk(input logic cke, input logic crst, input logic en,
                               input logic dir, input logic [3:0] step, input logic load,
                               input logic [7:0] lv, input logic clr,
                               input logic [7:0] ed, input logic et, input logic eo);
      vec_t v;
      v.cke = cke; v.crst = crst; v.en = en; v.dir = dir; v.step = step;
      v.load = load; v.lv = lv; v.clr = clr; v.ed = ed; v.et = et; v.eo = eo;
      return v;
   endfunction

   task automatic compare(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic drive(input logic cke, input logic crst, input logic en, input logic dir,
                        input logic [3:0] step, input logic load, input logic [7:0] lv,
                        input logic clr);
      cke_i = cke; counter_rst_i = crst; counter_en_i = en; dir_i = dir;
      step_i = step; load_i = load; load_val_i = lv; ovf_clr_i = clr;
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_sat(input string name, input logic [7:0] ed, input logic et,
                            input logic eo);
      compare({name, ".data"}, s_data, ed);
      compare({name, ".tc"}, {7'b0, s_tc}, {7'b0, et});
      compare({name, ".ovf"}, {7'b0, s_ovf}, {7'b0, eo});
   endtask

   initial begin
      //          cke crst en dir step load lv   clr  data tc ovf
      vecs[0]  = mk(1, 0, 0, 0, 4'd0, 1, 8'd8,   0, 8'd8, 0, 0);
      vecs[1]  = mk(1, 0, 1, 0, 4'd1, 0, 8'd0,   0, 8'd9, 0, 0);
      vecs[2]  = mk(1, 0, 1, 0, 4'd1, 0, 8'd0,   0, 8'd0, 1, 1);
      vecs[3]  = mk(1, 0, 0, 0, 4'd0, 0, 8'd0,   0, 8'd0, 0, 1);
      vecs[4]  = mk(1, 0, 0, 0, 4'd0, 1, 8'd1,   0, 8'd1, 0, 1);
      vecs[5]  = mk(1, 0, 1, 1, 4'd3, 0, 8'd0,   0, 8'd8, 1, 1);
      vecs[6]  = mk(1, 0, 0, 0, 4'd0, 0, 8'd0,   1, 8'd8, 0, 0);
      vecs[7]  = mk(1, 0, 1, 0, 4'd1, 1, 8'd5,   0, 8'd5, 0, 0);
      vecs[8]  = mk(1, 1, 0, 0, 4'd0, 1, 8'd7,   0, 8'd0, 0, 0);
      vecs[9]  = mk(1, 0, 0, 0, 4'd0, 1, 8'd200, 0, 8'd9, 0, 0);
      vecs[10] = mk(0, 0, 1, 0, 4'd1, 0, 8'd0,   0, 8'd9, 0, 0);
      vecs[11] = mk(1, 0, 1, 0, 4'd3, 0, 8'd0,   0, 8'd2, 1, 1);
      vecs[12] = mk(0, 0, 1, 0, 4'd1, 0, 8'd0,   1, 8'd2, 1, 1);
      vecs[13] = mk(1, 0, 1, 0, 4'd0, 0, 8'd0,   0, 8'd2, 0, 1);
      vecs[14] = mk(1, 0, 0, 0, 4'd0, 0, 8'd0,   1, 8'd2, 0, 0);
      vecs[15] = mk(1, 0, 1, 0, 4'd9, 0, 8'd0,   1, 8'd1, 1, 1);
      vecs[16] = mk(1, 0, 1, 1, 4'd1, 0, 8'd0,   0, 8'd0, 0, 1);
      vecs[17] = mk(1, 0, 1, 1, 4'd10, 0, 8'd0,  0, 8'd0, 1, 1);
      vecs[18] = mk(1, 0, 1, 0, 4'd10, 0, 8'd0,  0, 8'd0, 1, 1);
      vecs[19] = mk(1, 1, 0, 0, 4'd0, 0, 8'd0,   0, 8'd0, 0, 0);

      // Reset with cke_i low must still initialise both instances.
      rst_i = 1'b1;
      drive(0, 0, 0, 0, 4'd0, 0, 8'd0, 0);
      rst_i = 1'b0;
      compare("rst.wrap.data", w_data, 8'd0);
      compare("rst.wrap.tc", {7'b0, w_tc}, 8'd0);
      compare("rst.wrap.ovf", {7'b0, w_ovf}, 8'd0);
      check_sat("rst.sat", 8'd0, 0, 0);

      for (int i = 0; i < 20; i++) begin
         drive(vecs[i].cke, vecs[i].crst, vecs[i].en, vecs[i].dir, vecs[i].step,
               vecs[i].load, vecs[i].lv, vecs[i].clr);
         compare($sformatf("vec%0d.data", i), w_data, vecs[i].ed);
         compare($sformatf("vec%0d.tc", i), {7'b0, w_tc}, {7'b0, vecs[i].et});
         compare($sformatf("vec%0d.ovf", i), {7'b0, w_ovf}, {7'b0, vecs[i].eo});
      end

      // Saturate instance: clamping at both bounds, including repeated attempts.
      drive(1, 1, 0, 0, 4'd0, 0, 8'd0, 0);
      check_sat("sat.crst", 8'd0, 0, 0);
      drive(1, 0, 0, 0, 4'd0, 1, 8'd7, 0);
      check_sat("sat.load7", 8'd7, 0, 0);
      drive(1, 0, 1, 0, 4'd4, 0, 8'd0, 0);
      check_sat("sat.up4", 8'd9, 1, 1);
      drive(1, 0, 1, 0, 4'd4, 0, 8'd0, 0);
      check_sat("sat.up4_again", 8'd9, 1, 1);
      drive(1, 0, 0, 0, 4'd0, 1, 8'd0, 0);
      check_sat("sat.load0", 8'd0, 0, 1);
      drive(1, 0, 1, 1, 4'd2, 0, 8'd0, 0);
      check_sat("sat.down2", 8'd0, 1, 1);
      drive(1, 0, 1, 0, 4'd3, 0, 8'd0, 1);
      check_sat("sat.up3_clr", 8'd3, 0, 0);
      drive(1, 0, 1, 1, 4'd2, 0, 8'd0, 0);
      check_sat("sat.down2_inrange", 8'd1, 0, 0);
      drive(1, 0, 0, 0, 4'd0, 1, 8'd200, 0);
      check_sat("sat.load200", 8'd9, 0, 0);
      drive(1, 0, 1, 0, 4'd1, 0, 8'd0, 0);
      check_sat("sat.up1_at_max", 8'd9, 1, 1);

      // Reset from a non-zero, flagged state with cke_i low.
      rst_i = 1'b1;
      drive(0, 0, 1, 0, 4'd1, 0, 8'd0, 0);
      rst_i = 1'b0;
      check_sat("rst2.sat", 8'd0, 0, 0);
      compare("rst2.wrap.data", w_data, 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/iob_counter_mod.md
Name: iob_counter_mod

Overview:
Parametrised modulo up/down counter, the next generation of the plain increment counter. Adds a programmable step, direction control, parallel load, a bounded range [MIN_VAL, MAX_VAL], wrap or saturate mode, a terminal-count pulse and a sticky overflow flag. Used for prescalers, BCD-style counters, timeout counters and ring-buffer pointers in peripheral cores.

Parameters:
DATA_W, 8, counter width in bits.
STEP_W, 4, width of step input.
RST_VAL, 0, value loaded by rst_i and counter_rst_i; must lie in [MIN_VAL, MAX_VAL].
MIN_VAL, 0, lower bound of counting range.
MAX_VAL, 2**DATA_W-1, upper bound; requires MIN_VAL <= MAX_VAL.
SAT_MODE, 0, 0 = wrap at bounds, 1 = saturate at bounds.

Ports:
clk_i  input  1  clock
cke_i  input  1  clock enable; when 0, all state holds except for rst_i
rst_i  input  1  synchronous active-high reset
counter_rst_i  input  1  soft clear to RST_VAL
counter_en_i  input  1  count enable
dir_i  input  1  0 = up, 1 = down
step_i  input  STEP_W  increment/decrement amount
load_i  input  1  parallel load strobe
load_val_i  input  DATA_W  value to load
ovf_clr_i  input  1  clears ovf_o
data_o  output  DATA_W  registered count
tc_o  output  1  registered terminal-count pulse
ovf_o  output  1  sticky overflow/underflow flag

Behaviour:
- Reset interface (decided): one clock (clk_i); reset is synchronous and active-high (rst_i).
- rst_i=1 at a clk_i rising edge sets data_o=RST_VAL, tc_o=0, ovf_o=0. This acts regardless of cke_i.
- cke_i=0 with rst_i=0: data_o, tc_o and ovf_o all hold.
- Priority with cke_i=1: counter_rst_i > load_i > counter_en_i.
- counter_rst_i: data_o=RST_VAL, tc_o=0, ovf_o=0.
- load_i: data_o is load_val_i clamped into [MIN_VAL, MAX_VAL]. tc_o=0. ovf_o is unaffected except by ovf_clr_i.
- counter_en_i: one update per enabled edge; latency 1 cycle; no other state.
- Arithmetic uses an internal width of DATA_W+STEP_W+1 bits, so there is no intermediate overflow.
- Up count: n = cur+step. Out of range when n > MAX_VAL.
- Down count: out of range when cur-MIN_VAL < step.
- Wrap mode, up: data_o = MIN_VAL + (n - MAX_VAL - 1).
- Wrap mode, down: data_o = MAX_VAL - (step - (cur - MIN_VAL) - 1).
- Wrap mode requires step_i <= MAX_VAL-MIN_VAL+1. A simulation-only assertion flags a violation; the result is then undefined.
- Saturate mode: an out-of-range update clamps data_o to MAX_VAL (up) or MIN_VAL (down). This includes attempts made while already at the bound.
- tc_o=1 for exactly the cycle following an out-of-range update, aligned with the new data_o. Otherwise tc_o=0.
- step_i=0 with counter_en_i=1: data_o holds, tc_o=0.
- ovf_o is set on any out-of-range update and cleared by ovf_clr_i. If set and clear occur in the same cycle, set wins.
- Degenerate range MIN_VAL==MAX_VAL: data_o is constant; every enabled non-zero step raises tc_o.

Decomposition:
- Package iob_counter_mod_pkg: mode constants (WRAP=0, SAT=1), direction constants (UP=0, DOWN=1), internal width localparam.
- One natural sub-module: iob_counter_mod_next. This is the combinational next-value/out-of-range calculator.
- The top module holds the data, tc and ovf registers and the priority logic.

Test Plan:
All scenarios use DATA_W=8, MIN_VAL=0, MAX_VAL=9, RST_VAL=0, SAT_MODE=0 unless stated.
1. Reset: assert rst_i with cke_i=0 -> data_o=0, tc_o=0, ovf_o=0 at the next edge.
2. Up wrap: load 8, then en, up, step 1 for 2 cycles -> data_o 9 then 0. tc_o=1 only with data_o=0. ovf_o=1 and stays 1.
3. Down wrap: load 1, then en, down, step 3 -> data_o=8, tc_o=1. Then ovf_clr_i=1 with no overflow -> ovf_o=0.
4. Saturate (SAT_MODE=1): load 7, then up, step 4 -> data_o=9, tc_o=1. Another enabled cycle -> data_o=9, tc_o=1. Down from 0 with step 2 -> data_o=0, tc_o=1.
5. Priority and clamp:
   - load_i and counter_en_i together with load_val_i=5 -> data_o=5.
   - counter_rst_i together with load_i -> data_o=0.
   - load_val_i=200 -> data_o=9.
   - cke_i=0 with en -> data_o unchanged.
6. Flag race: overflow event and ovf_clr_i in the same cycle -> ovf_o=1. step_i=0 with en -> data_o unchanged, tc_o=0.
